// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: default sizes, PC index helper and word typedefs shared by the register bank,
// the instruction FSM and the ALU.
package reg_bank_pkg;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 16;
   localparam int DEF_RESET_PC = 0;
   localparam int DEF_PC_STEP  = 1;
   typedef logic [$clog2(DEF_NUM_REGS)-1:0] addr_t;
   typedef logic [DEF_DATA_W-1:0]           data_t;
   function automatic int pc_idx(input int num_regs);
      return num_regs - 1;
   endfunction
endpackage

// File: rtl/reg_bank_rd_port.sv
// reg_bank_rd_port: one registered read port; with REG_BANK_BYPASS_EN defined it reads the
// bank's next-state contents so a same-edge write or PC update is returned.
module reg_bank_rd_port
   import reg_bank_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0] regs_q_i [NUM_REGS],
`ifdef REG_BANK_BYPASS_EN
   input  logic [DATA_W-1:0] regs_d_i [NUM_REGS],
`endif
   output logic [DATA_W-1:0] rd_data_o
);
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   always_comb begin
`ifdef REG_BANK_BYPASS_EN
      rd_data_d = rd_en_i ? regs_d_i[rd_addr_i] : rd_data_q;
`else
      rd_data_d = rd_en_i ? regs_q_i[rd_addr_i] : rd_data_q;
`endif
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) rd_data_q <= '0;
      else     rd_data_q <= rd_data_d;
   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/reg_bank.sv
// reg_bank: register bank with two registered read ports, one write port and a PC in the top
// register; REG_BANK_BYPASS_EN selects write-to-read forwarding on same-edge accesses.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                NUM_REGS = DEF_NUM_REGS,
   parameter int                ADDR_W   = $clog2(NUM_REGS),
   parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEF_RESET_PC),
   parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(DEF_PC_STEP)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en_a,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic              rd_en_b,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pc_inc,
   output logic [DATA_W-1:0] pc_out
);
   localparam int PC_IDX = pc_idx(NUM_REGS);
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              pc_wr;
   assign pc_wr = wr_en && (wr_addr == ADDR_W'(PC_IDX));
   // an explicit PC write (jump) overrides the increment on the same edge
   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wr_addr] = wr_data;
      regs_d[PC_IDX] = pc_wr ? wr_data : pc_inc ? regs_q[PC_IDX] + PC_STEP : regs_q[PC_IDX];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == PC_IDX) ? RESET_PC : '0;
      else     regs_q <= regs_d;
   assign pc_out = regs_q[PC_IDX];
   reg_bank_rd_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rd_a (
      .clk(clk), .rst(rst), .rd_en_i(rd_en_a), .rd_addr_i(rd_addr_a), .regs_q_i(regs_q),
`ifdef REG_BANK_BYPASS_EN
      .regs_d_i(regs_d),
`endif
      .rd_data_o(rd_data_a)
   );
   reg_bank_rd_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rd_b (
      .clk(clk), .rst(rst), .rd_en_i(rd_en_b), .rd_addr_i(rd_addr_b), .regs_q_i(regs_q),
`ifdef REG_BANK_BYPASS_EN
      .regs_d_i(regs_d),
`endif
      .rd_data_o(rd_data_b)
   );
endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised register bank for the 16-bit RISC datapath, and the successor to the single shared-bus register file. It has two independent registered read ports and one write port, replacing the bidirectional data bus. The top register is the program counter, with reset load and auto-increment. The instruction FSM drives addresses and enables; the ALU and memory interface consume the read data.

## Interface
Parameters:
- DATA_W, 16, register width in bits (8..64)
- NUM_REGS, 16, number of registers; power of two, minimum 4
- ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden)
- RESET_PC, 0, value loaded into the PC register at reset
- PC_STEP, 1, value added to the PC on each pc_inc

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- rd_en_a  in  1  read request, port A
- rd_addr_a  in  ADDR_W  read address, port A
- rd_data_a  out  DATA_W  registered read data, port A
- rd_en_b  in  1  read request, port B
- rd_addr_b  in  ADDR_W  read address, port B
- rd_data_b  out  DATA_W  registered read data, port B
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- pc_inc  in  1  advance the PC by PC_STEP
- pc_out  out  DATA_W  current PC (register NUM_REGS-1), continuously visible

## Operation
- Storage: NUM_REGS x DATA_W flops. PC_IDX = NUM_REGS-1.
- Reset (rst=1, asynchronous):
  - registers 0..NUM_REGS-2 clear to 0
  - PC loads RESET_PC
  - rd_data_a and rd_data_b clear to 0
  - pc_out reflects RESET_PC immediately
- Write: wr_en=1 at a clock edge stores wr_data into reg[wr_addr]. Any address is writable, including PC_IDX (jump/branch).
- PC update priority per edge:
  - wr_en with wr_addr==PC_IDX: PC takes wr_data; pc_inc is ignored that cycle.
  - otherwise pc_inc=1: PC takes PC+PC_STEP, truncated to DATA_W (wraps modulo 2^DATA_W).
  - otherwise PC holds.
- Read: on an edge with rd_en_x=1, rd_data_x captures reg[rd_addr_x].
  - With rd_en_x=0, rd_data_x holds its previous value.
  - Ports A and B are fully independent; the same address on both is legal and both receive the same data.
- Same-edge read/write to the same address: behaviour set by the bypass macro (see Configuration).
- There are no illegal addresses; every ADDR_W code maps to a register.

## Timing
- Read latency: 1 cycle. Address and enable are sampled at edge N; data is valid after edge N and is held until the next enabled edge.
- Write latency: written value is visible at pc_out, or to a read issued at edge N+1, after edge N.
- pc_out is combinational from the PC flop, with no extra stage.
- Reset mid-operation: asynchronous clear takes effect at once. The first edge after rst deasserts performs normal operation. Writes and reads pending on that edge are honoured; none are lost or replayed.
- No handshake; the bank accepts one write and two reads every cycle without stalling.

## Configuration
- REG_BANK_BYPASS_EN defined: a read at edge N whose address matches a write or PC update at edge N returns the new value.
  - Matching write: read returns wr_data.
  - Matching PC increment: read of PC_IDX returns PC+PC_STEP.
  - Matching write to PC_IDX: read returns wr_data, which takes priority over the increment.
- REG_BANK_BYPASS_EN undefined: reads always return the pre-edge contents (old value). The FSM must insert one cycle between a write and a dependent read.

## Structure
- Shared package reg_bank_pkg:
  - default constants for DATA_W, NUM_REGS, RESET_PC and PC_STEP
  - localparam function for the PC index
  - typedef for register-address and data words, used by the FSM and ALU
- Sub-module reg_bank_rd_port, instantiated twice (A, B):
  - address mux
  - optional bypass compare/select
  - output hold register, with async reset to 0
- The top level owns storage, write decode and the PC update logic.

## Test plan
- Reset: assert rst asynchronously mid-cycle with RESET_PC=16'h00A1 -> pc_out=16'h00A1 immediately; rd_data_a/b=0; reads of r0..r14 return 0 after release.
- Write/read both ports: write r3=16'h1234 and r7=16'hBEEF; next cycle read A=r3, B=r7 -> 16'h1234 and 16'hBEEF one cycle later. Drop rd_en -> outputs hold.
- PC increment wrap: load PC=16'hFFFF via write to r15, then pc_inc for 2 cycles -> pc_out 16'h0000, then 16'h0001.
- Write/increment conflict: wr_en to r15 with 16'h0200 plus pc_inc on the same edge -> pc_out=16'h0200, not 16'h0201.
- Same-edge hazard: r5=16'h0011, then write r5=16'h0022 while reading r5 on A. Expected rd_data_a=16'h0022 with REG_BANK_BYPASS_EN, 16'h0011 without.
- Parameter sweep: DATA_W=32, NUM_REGS=32 -> PC is r31, increment wraps at 32'hFFFFFFFF, and all addresses are read/write distinct.
